// File: rtl/onehot_monitor.sv
`default_nettype none
// ============================================================================
// Module      : onehot_monitor
// Description : One-stage registered valid/ready slice that classifies each
//               accepted vector as zero-hot, one-hot or multi-hot, reports the
//               lowest set bit index, and tracks violations with a sticky
//               error flag and a saturating counter.
// Ports       : clk_i, rst_ni (async, active-low), clear_i
//               valid_i / ready_o / d_i        -- upstream handshake + vector
//               valid_o / ready_i / d_o        -- downstream handshake + copy
//               is_onehot_o, is_zero_o, multi_hot_o, idx_o, violation_o
//               error_o (sticky), err_cnt_o (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_monitor #(
    parameter int  Width     = 8,
    parameter bit  AllowZero = 1'b0,
    parameter int  CntWidth  = 16,
    localparam int IdxWidth  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [Width-1:0]    d_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Width-1:0]    d_o,
    output logic                is_onehot_o,
    output logic                is_zero_o,
    output logic                multi_hot_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                violation_o,
    output logic                error_o,
    output logic [CntWidth-1:0] err_cnt_o
);

    logic                any_set;
    logic                multi_set;
    logic [IdxWidth-1:0] idx_c;
    logic                viol_c;
    logic                accept;

    // Serial half-adder chain: any_set is the running OR (sum saturates at 1),
    // multi_set is the OR of every carry that a second set bit would produce.
    always_comb begin
        any_set   = 1'b0;
        multi_set = 1'b0;
        for (int i = 0; i < Width; i++) begin
            multi_set = multi_set | (any_set & d_i[i]);
            any_set   = any_set | d_i[i];
        end
    end

    // Lowest-set-bit priority encoder: scanning downward lets the lowest
    // set bit win. Stays 0 for an all-zero vector.
    always_comb begin
        idx_c = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (d_i[i]) begin
                idx_c = IdxWidth'(i);
            end
        end
    end

    assign viol_c  = multi_set | (~any_set & ~AllowZero);

    // Only depends on registered state and ready_i, keeping the slice
    // free of a valid_i -> ready_o combinational path.
    assign ready_o = ~valid_o | ready_i;
    assign accept  = valid_i & ready_o;

    // Output register: payload only loads on accept and otherwise holds,
    // including after being drained.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o     <= 1'b0;
            d_o         <= '0;
            is_onehot_o <= 1'b0;
            is_zero_o   <= 1'b0;
            multi_hot_o <= 1'b0;
            idx_o       <= '0;
            violation_o <= 1'b0;
        end else if (accept) begin
            valid_o     <= 1'b1;
            d_o         <= d_i;
            is_onehot_o <= any_set & ~multi_set;
            is_zero_o   <= ~any_set;
            multi_hot_o <= multi_set;
            idx_o       <= idx_c;
            violation_o <= viol_c;
        end else if (ready_i) begin
            valid_o     <= 1'b0;
        end
    end

    // Error tracking: clear wins over a same-cycle violation, which is then
    // dropped rather than counted afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            error_o   <= 1'b0;
            err_cnt_o <= '0;
        end else if (clear_i) begin
            error_o   <= 1'b0;
            err_cnt_o <= '0;
        end else if (accept && viol_c) begin
            error_o <= 1'b1;
            if (err_cnt_o != {CntWidth{1'b1}}) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onehot_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_monitor
// Description : Directed self-checking bench for onehot_monitor. Three
//               instances share one stimulus stream: the default build
//               (Width=8, AllowZero=0, CntWidth=16), a zero-tolerant build
//               with a 2-bit counter, and a Width=1 build fed bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_monitor;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       valid_in;
    logic       ready_in;
    logic [7:0] d;

    // default instance
    logic        a_ready, a_valid, a_one, a_zero, a_multi, a_viol, a_err;
    logic [7:0]  a_d;
    logic [2:0]  a_idx;
    logic [15:0] a_cnt;

    // AllowZero=1, CntWidth=2 instance
    logic        b_ready, b_valid, b_one, b_zero, b_multi, b_viol, b_err;
    logic [7:0]  b_d;
    logic [2:0]  b_idx;
    logic [1:0]  b_cnt;

    // Width=1 instance
    logic        c_ready, c_valid, c_one, c_zero, c_multi, c_viol, c_err;
    logic [0:0]  c_d;
    logic [0:0]  c_idx;
    logic [15:0] c_cnt;

    int n_total;
    int n_bad;

    onehot_monitor u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .valid_i(valid_in), .ready_o(a_ready), .d_i(d),
        .valid_o(a_valid), .ready_i(ready_in), .d_o(a_d),
        .is_onehot_o(a_one), .is_zero_o(a_zero), .multi_hot_o(a_multi),
        .idx_o(a_idx), .violation_o(a_viol), .error_o(a_err), .err_cnt_o(a_cnt)
    );

    onehot_monitor #(.Width(8), .AllowZero(1'b1), .CntWidth(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .valid_i(valid_in), .ready_o(b_ready), .d_i(d),
        .valid_o(b_valid), .ready_i(ready_in), .d_o(b_d),
        .is_onehot_o(b_one), .is_zero_o(b_zero), .multi_hot_o(b_multi),
        .idx_o(b_idx), .violation_o(b_viol), .error_o(b_err), .err_cnt_o(b_cnt)
    );

    onehot_monitor #(.Width(1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .valid_i(valid_in), .ready_o(c_ready), .d_i(d[0:0]),
        .valid_o(c_valid), .ready_i(ready_in), .d_o(c_d),
        .is_onehot_o(c_one), .is_zero_o(c_zero), .multi_hot_o(c_multi),
        .idx_o(c_idx), .violation_o(c_viol), .error_o(c_err), .err_cnt_o(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        d        = 8'h00;

        // ---------------- reset state ----------------
        #3;
        check("rst valid_o", {31'd0, a_valid}, 32'd0);
        check("rst ready_o", {31'd0, a_ready}, 32'd1);
        check("rst flags",   {28'd0, a_one, a_zero, a_multi, a_viol}, 32'd0);
        check("rst err_cnt", {16'd0, a_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- classification ----------------
        valid_in = 1'b1;
        d = 8'h10; tick();
        check("10 valid_o", {31'd0, a_valid}, 32'd1);
        check("10 z/1/m",   {29'd0, a_zero, a_one, a_multi}, 32'b010);
        check("10 idx",     {29'd0, a_idx}, 32'd4);
        check("10 viol",    {31'd0, a_viol}, 32'd0);
        check("10 d_o",     {24'd0, a_d}, 32'h10);
        check("10 cnt",     {16'd0, a_cnt}, 32'd0);

        d = 8'h00; tick();
        check("00 z/1/m",   {29'd0, a_zero, a_one, a_multi}, 32'b100);
        check("00 idx",     {29'd0, a_idx}, 32'd0);
        check("00 viol",    {31'd0, a_viol}, 32'd1);
        check("00 cnt",     {16'd0, a_cnt}, 32'd1);
        check("00 az viol", {31'd0, b_viol}, 32'd0);
        check("00 az zero", {31'd0, b_zero}, 32'd1);
        check("00 az cnt",  {30'd0, b_cnt}, 32'd0);

        d = 8'h81; tick();
        check("81 z/1/m",   {29'd0, a_zero, a_one, a_multi}, 32'b001);
        check("81 idx",     {29'd0, a_idx}, 32'd0);
        check("81 viol",    {31'd0, a_viol}, 32'd1);
        check("81 cnt",     {16'd0, a_cnt}, 32'd2);
        check("81 az cnt",  {30'd0, b_cnt}, 32'd1);
        check("w1 z/1/m",   {29'd0, c_zero, c_one, c_multi}, 32'b010);
        check("w1 idx",     {31'd0, c_idx}, 32'd0);

        d = 8'h01; tick();
        check("01 z/1/m",   {29'd0, a_zero, a_one, a_multi}, 32'b010);
        check("01 idx",     {29'd0, a_idx}, 32'd0);
        check("01 viol",    {31'd0, a_viol}, 32'd0);
        check("class err",  {31'd0, a_err}, 32'd1);
        check("class cnt",  {16'd0, a_cnt}, 32'd2);

        // drain: valid_o falls, payload holds
        valid_in = 1'b0; tick();
        check("drain valid_o", {31'd0, a_valid}, 32'd0);
        check("drain d_o",     {24'd0, a_d}, 32'h01);

        // clear with no transfer
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr cnt", {16'd0, a_cnt}, 32'd0);
        check("clr err", {31'd0, a_err}, 32'd0);

        // ---------------- back-pressure ----------------
        valid_in = 1'b1;
        d = 8'h04; tick();
        check("bp d_o", {24'd0, a_d}, 32'h04);
        ready_in = 1'b0;
        d = 8'hFF;
        #1;
        check("bp ready_o", {31'd0, a_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp stall d_o",   {24'd0, a_d}, 32'h04);
            check("bp stall cnt",   {16'd0, a_cnt}, 32'd0);
            check("bp stall ready", {31'd0, a_ready}, 32'd0);
            check("bp stall valid", {31'd0, a_valid}, 32'd1);
        end
        ready_in = 1'b1;
        #1;
        check("bp release ready", {31'd0, a_ready}, 32'd1);
        tick();
        check("bp FF d_o",  {24'd0, a_d}, 32'hFF);
        check("bp FF mh",   {31'd0, a_multi}, 32'd1);
        check("bp FF cnt",  {16'd0, a_cnt}, 32'd1);
        check("bp FF idx",  {29'd0, a_idx}, 32'd0);

        // ---------------- saturation ----------------
        clear = 1'b1; valid_in = 1'b0; tick(); clear = 1'b0;
        valid_in = 1'b1;
        d = 8'h03;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("sat cnt2",  {30'd0, b_cnt}, (i < 3) ? i : 3);
            check("sat cnt16", {16'd0, a_cnt}, i);
        end

        // ---------------- clear priority ----------------
        valid_in = 1'b0; clear = 1'b1; tick(); clear = 1'b0;
        valid_in = 1'b1; d = 8'h06; tick(); tick();
        check("cp pre cnt", {16'd0, a_cnt}, 32'd2);
        clear = 1'b1; d = 8'h03; tick(); clear = 1'b0;
        check("cp cnt",   {16'd0, a_cnt}, 32'd0);
        check("cp err",   {31'd0, a_err}, 32'd0);
        check("cp mh",    {31'd0, a_multi}, 32'd1);
        check("cp valid", {31'd0, a_valid}, 32'd1);
        check("cp d_o",   {24'd0, a_d}, 32'h03);

        // ---------------- asynchronous reset mid-transfer ----------------
        tick(); tick(); tick();
        valid_in = 1'b0; ready_in = 1'b0;
        tick();
        check("mr pre cnt",   {16'd0, a_cnt}, 32'd3);
        check("mr pre valid", {31'd0, a_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr valid_o", {31'd0, a_valid}, 32'd0);
        check("mr ready_o", {31'd0, a_ready}, 32'd1);
        check("mr d_o",     {24'd0, a_d}, 32'd0);
        check("mr flags",   {28'd0, a_one, a_zero, a_multi, a_viol}, 32'd0);
        check("mr idx",     {29'd0, a_idx}, 32'd0);
        check("mr err",     {31'd0, a_err}, 32'd0);
        check("mr cnt",     {16'd0, a_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
